// File: rtl/clock_set_ctrl_pkg.sv
// rtl/clock_set_ctrl_pkg.sv - shared mode encodings, FSM state type and counter sizing helper
package clock_set_ctrl_pkg;

    // Mode codes seen by the datapath and the FND controller (field blinking)
    localparam logic [1:0] MODE_RUN  = 2'd0;
    localparam logic [1:0] MODE_HOUR = 2'd1;
    localparam logic [1:0] MODE_MIN  = 2'd2;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOUR = 2'd1,
        ST_MIN  = 2'd2
    } state_e;

    // Width able to hold 0..max_val, never narrower than one bit
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/clock_ctrl_tick.sv
// rtl/clock_ctrl_tick.sv - free-running divider producing a one-cycle tick strobe every DIV clocks
module clock_ctrl_tick #(
    parameter int DIV = 100_000
) (
    input  logic iClk,
    input  logic iRst,
    output logic oTick
);

    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Count 0..DIV-1 and fire a registered strobe on the wrap
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == LAST) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
        end
    end

    assign oTick = r_tick;

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - set-mode FSM, adjust pulses with hold-to-repeat, inactivity timeout and field blink
module clock_set_ctrl
    import clock_set_ctrl_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int TICK_HZ    = 1000,
    parameter int HOLD_MS    = 500,
    parameter int REPEAT_MS  = 100,
    parameter int TIMEOUT_MS = 10000,
    parameter int BLINK_MS   = 250
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iBtn_Set,
    input  logic       iBtn_Up,
    input  logic       iBtn_Down,
    output logic       oSet,
    output logic       oHour_Up,
    output logic       oHour_Down,
    output logic       oMin_Up,
    output logic       oMin_Down,
    output logic [1:0] oMode,
    output logic       oBlink
);

    localparam int DIV = CLK_FREQ / TICK_HZ;

    localparam int HOLD_W = cnt_width(HOLD_MS);
    localparam int REP_W  = cnt_width(REPEAT_MS);
    localparam int TO_W   = cnt_width(TIMEOUT_MS);
    localparam int BL_W   = cnt_width(BLINK_MS);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MS > 0) ? HOLD_MS - 1 : 0);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_MS);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEAT_MS > 0) ? REPEAT_MS - 1 : 0);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REPEAT_MS);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'((TIMEOUT_MS > 0) ? TIMEOUT_MS - 1 : 0);
    localparam logic [TO_W-1:0]   TO_MAX    = TO_W'(TIMEOUT_MS);
    localparam logic [BL_W-1:0]   BL_LAST   = BL_W'((BLINK_MS > 0) ? BLINK_MS - 1 : 0);
    localparam logic              TO_EN     = (TIMEOUT_MS > 0);

    logic              w_tick;

    state_e            r_state;
    logic [1:0]        r_mode;
    logic              r_set;

    logic              r_set_q;
    logic              r_up_q;
    logic              r_dn_q;

    logic              r_armed;
    logic              r_repeating;
    logic [HOLD_W-1:0] r_hold;
    logic [REP_W-1:0]  r_rep;

    logic [TO_W-1:0]   r_to;
    logic [BL_W-1:0]   r_blink_cnt;
    logic              r_blink;

    logic              r_hour_up;
    logic              r_hour_dn;
    logic              r_min_up;
    logic              r_min_dn;

    logic              w_set_edge;
    logic              w_up_edge;
    logic              w_dn_edge;
    logic              w_any_btn;
    logic              w_in_set;
    logic              w_one;
    logic              w_adj_edge;
    logic              w_adj_active;
    logic              w_rep_due;
    logic              w_pulse;
    logic              w_to_hit;
    logic              w_enter;
    logic              w_to_run;

    clock_ctrl_tick #(
        .DIV (DIV)
    ) u_tick (
        .iClk  (iClk),
        .iRst  (iRst),
        .oTick (w_tick)
    );

    assign w_set_edge = iBtn_Set  & ~r_set_q;
    assign w_up_edge  = iBtn_Up   & ~r_up_q;
    assign w_dn_edge  = iBtn_Down & ~r_dn_q;
    assign w_any_btn  = iBtn_Set | iBtn_Up | iBtn_Down;
    assign w_in_set   = (r_state != ST_RUN);

    // Exactly one of Up/Down pressed; both together means "do nothing"
    assign w_one        = iBtn_Up ^ iBtn_Down;
    assign w_adj_edge   = w_one & (iBtn_Up ? w_up_edge : w_dn_edge);
    // A Set edge owns the cycle, so adjusting is suppressed while the field changes
    assign w_adj_active = w_in_set & ~w_set_edge & w_one;
    assign w_rep_due    = r_armed & w_tick &
                          (r_repeating ? (r_rep == REP_LAST) : (r_hold == HOLD_LAST));
    assign w_pulse      = w_adj_active & (w_adj_edge | w_rep_due);

    assign w_to_hit = TO_EN & w_in_set & w_tick & ~w_any_btn & (r_to == TO_LAST);
    assign w_enter  = w_set_edge & (r_state != ST_MIN);
    assign w_to_run = (w_set_edge & (r_state == ST_MIN)) | w_to_hit;

    // Previous button levels; loading the live level during reset keeps a held button from edging on release
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_set_q <= iBtn_Set;
            r_up_q  <= iBtn_Up;
            r_dn_q  <= iBtn_Down;
        end else begin
            r_set_q <= iBtn_Set;
            r_up_q  <= iBtn_Up;
            r_dn_q  <= iBtn_Down;
        end
    end

    // Mode FSM: Set edges step RUN->HOUR->MIN->RUN, inactivity drops back to RUN
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_RUN;
            r_mode  <= MODE_RUN;
            r_set   <= 1'b0;
        end else if (w_set_edge) begin
            case (r_state)
                ST_RUN: begin
                    r_state <= ST_HOUR;
                    r_mode  <= MODE_HOUR;
                    r_set   <= 1'b1;
                end
                ST_HOUR: begin
                    r_state <= ST_MIN;
                    r_mode  <= MODE_MIN;
                    r_set   <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                    r_mode  <= MODE_RUN;
                    r_set   <= 1'b0;
                end
            endcase
        end else if (w_to_hit) begin
            r_state <= ST_RUN;
            r_mode  <= MODE_RUN;
            r_set   <= 1'b0;
        end
    end

    // Hold/repeat tracking; only a fresh press in the current field arms auto-repeat
    always_ff @(posedge iClk) begin
        if (iRst || !w_adj_active) begin
            r_armed     <= 1'b0;
            r_repeating <= 1'b0;
            r_hold      <= '0;
            r_rep       <= '0;
        end else if (w_adj_edge) begin
            r_armed     <= 1'b1;
            r_repeating <= 1'b0;
            r_hold      <= '0;
            r_rep       <= '0;
        end else if (r_armed && w_tick) begin
            if (!r_repeating) begin
                if (r_hold == HOLD_LAST) begin
                    r_repeating <= 1'b1;
                    r_rep       <= '0;
                end else if (r_hold != HOLD_MAX) begin
                    r_hold <= r_hold + HOLD_W'(1);
                end
            end else if (r_rep == REP_LAST) begin
                r_rep <= '0;
            end else if (r_rep != REP_MAX) begin
                r_rep <= r_rep + REP_W'(1);
            end
        end
    end

    // Route the single adjust pulse to the field of the current mode and the pressed direction
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_hour_up <= 1'b0;
            r_hour_dn <= 1'b0;
            r_min_up  <= 1'b0;
            r_min_dn  <= 1'b0;
        end else begin
            r_hour_up <= w_pulse & (r_state == ST_HOUR) & iBtn_Up;
            r_hour_dn <= w_pulse & (r_state == ST_HOUR) & iBtn_Down;
            r_min_up  <= w_pulse & (r_state == ST_MIN)  & iBtn_Up;
            r_min_dn  <= w_pulse & (r_state == ST_MIN)  & iBtn_Down;
        end
    end

    // Inactivity counter: cleared while any button is down, saturating tick count otherwise
    always_ff @(posedge iClk) begin
        if (iRst || w_any_btn) begin
            r_to <= '0;
        end else if (w_tick && (r_to != TO_MAX)) begin
            r_to <= r_to + TO_W'(1);
        end
    end

    // Blink: dark in RUN, forced on at field entry or an adjust, else toggles each BLINK_MS ticks
    always_ff @(posedge iClk) begin
        if (iRst || w_to_run || (!w_in_set && !w_enter)) begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_enter || w_pulse) begin
            r_blink     <= 1'b1;
            r_blink_cnt <= '0;
        end else if (w_tick) begin
            if (r_blink_cnt == BL_LAST) begin
                r_blink     <= ~r_blink;
                r_blink_cnt <= '0;
            end else begin
                r_blink_cnt <= r_blink_cnt + BL_W'(1);
            end
        end
    end

    assign oSet       = r_set;
    assign oMode      = r_mode;
    assign oHour_Up   = r_hour_up;
    assign oHour_Down = r_hour_dn;
    assign oMin_Up    = r_min_up;
    assign oMin_Down  = r_min_dn;
    assign oBlink     = r_blink;

endmodule
